// File: rtl/uart_rx.sv
// uart_rx: serial UART receiver for start/data/stop framed words.
//
// Frames are one start bit (0), DATA_WIDTH data bits LSB first and one stop bit (1).
// Bit timing is fixed by BAUD_RATE clocks per bit. The start bit is re-checked at its
// midpoint, and every following bit is sampled one full bit period later, which keeps
// each sample near the middle of its bit.
//
// Parameters:
//   BAUD_RATE  - clocks per bit period (>= 4)
//   DATA_WIDTH - data bits per frame
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset, clears all state
//   in        in   raw serial line, asynchronous to clk, idle high
//   ready     in   consumer accepts data when valid is also high
//   valid     out  data holds an unconsumed word
//   data      out  last good received word, stable while valid is high
//   frame_err out  one-cycle pulse when a stop bit samples low
//   overrun   out  one-cycle pulse when a good word is dropped because valid was held
//   busy      out  receiver is inside a frame (state not idle)

module uart_rx #(
    parameter int unsigned BAUD_RATE  = 870,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned HALF = BAUD_RATE / 2;
    localparam int unsigned CW   = $clog2(BAUD_RATE);
    localparam int unsigned BW   = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_RATE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // All reset to the idle line level so reset never manufactures an edge.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;
    logic                    cnt_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Only a fresh high-to-low transition starts a frame; a line stuck low does not.
    assign rx_fall  = !rx_s_q && rx_prev_q;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer handshake; a good stop sample below may re-set valid in the same cycle.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    cnt_d   = CNT_HALF;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_zero) begin
                    if (!rx_s_q) begin
                        cnt_d     = CNT_FULL;
                        bit_idx_d = '0;
                        state_d   = StData;
                    end else begin
                        // Line back high at mid-start: a glitch, drop it silently.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            StData: begin
                if (cnt_zero) begin
                    shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    bit_idx_d = bit_idx_q + BIT_ONE;
                    cnt_d     = CNT_FULL;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            StStop: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                    if (rx_s_q) begin
                        if (!valid_q || ready) begin
                            // Free slot, or the held word is being taken this very cycle.
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            // Keep the unread word; the new one is lost.
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// A short bit period keeps the run small; all timing is expressed in terms of it.

module tb_uart_rx;

    localparam int unsigned B    = 16;
    localparam int unsigned HALF = B / 2;
    localparam int unsigned DW   = 8;

    logic          clk;
    logic          reset;
    logic          line;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Cycle counters fed from the DUT outputs, sampled on the falling edge.
    int            fe_cnt    = 0;
    int            ov_cnt    = 0;
    int            busy_cnt  = 0;
    int            val_cnt   = 0;
    int            acc_cnt   = 0;
    logic [DW-1:0] last_acc  = '0;

    uart_rx #(
        .BAUD_RATE (B),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (line),
        .ready    (ready),
        .valid    (valid),
        .data     (data),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
        if (busy)      busy_cnt <= busy_cnt + 1;
        if (valid)     val_cnt <= val_cnt + 1;
        if (valid && ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_ov;
        int         exp_acc;
    } vec_t;

    vec_t vecs[4];

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        wait_cycles(B);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int fe0, ov0, busy0, val0, acc0, busy_rel;

    initial begin
        vecs[0] = '{d: 8'hA5, stop: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_data: 8'hA5,
                    exp_fe: 0, exp_ov: 0, exp_acc: 1};
        vecs[1] = '{d: 8'h11, stop: 1'b1, rdy: 1'b0, exp_valid: 1'b1, exp_data: 8'h11,
                    exp_fe: 0, exp_ov: 0, exp_acc: 0};
        vecs[2] = '{d: 8'h22, stop: 1'b1, rdy: 1'b0, exp_valid: 1'b1, exp_data: 8'h11,
                    exp_fe: 0, exp_ov: 1, exp_acc: 0};
        vecs[3] = '{d: 8'h33, stop: 1'b0, rdy: 1'b0, exp_valid: 1'b1, exp_data: 8'h11,
                    exp_fe: 1, exp_ov: 0, exp_acc: 0};

        reset = 1'b1;
        line  = 1'b1;
        ready = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);

        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Start glitch: short low pulse, start re-check at mid-bit finds the line high.
        busy0 = busy_cnt; val0 = val_cnt; fe0 = fe_cnt;
        line = 1'b0;
        wait_cycles(4);
        line = 1'b1;
        wait_cycles(2 * B);
        check("glitch_busy_cycles", 32'(busy_cnt - busy0), 32'(HALF));
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(val_cnt - val0), 32'd0);
        check("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

        // Framing error, then line held low: no restart until a new falling edge.
        fe0 = fe_cnt; val0 = val_cnt; ov0 = ov_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] fd;
            fd = 8'h3C;
            drive_bit(fd[i]);
        end
        line = 1'b0;
        wait_cycles(4 * B);
        check("ferr_pulse_cycles", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_valid", 32'(val_cnt - val0), 32'd0);
        check("ferr_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("ferr_idle_while_low", 32'(busy), 32'd0);
        busy0 = busy_cnt;
        line = 1'b1;
        wait_cycles(B);
        check("ferr_rise_no_start", 32'(busy_cnt - busy0), 32'd0);

        // Table: single frame, then back-to-back frames with ready low (overrun, frame error).
        for (int v = 0; v < 4; v++) begin
            fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
            ready = vecs[v].rdy;
            send_frame(vecs[v].d, vecs[v].stop);
            check($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_frame_err", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_overrun", v), 32'(ov_cnt - ov0), 32'(vecs[v].exp_ov));
            check($sformatf("vec%0d_accepts", v), 32'(acc_cnt - acc0), 32'(vecs[v].exp_acc));
            if (vecs[v].exp_acc != 0) begin
                check($sformatf("vec%0d_acc_data", v), 32'(last_acc), 32'(vecs[v].d));
            end
        end
        line = 1'b1;
        wait_cycles(B);

        // Releasing ready delivers only the first held word.
        acc0 = acc_cnt;
        ready = 1'b1;
        wait_cycles(3);
        ready = 1'b0;
        check("drain_accepts", 32'(acc_cnt - acc0), 32'd1);
        check("drain_data", 32'(last_acc), 32'h11);
        check("drain_valid", 32'(valid), 32'd0);

        // Accept coincides with the stop sample of the next frame.
        send_frame(8'h55, 1'b1);
        check("pend55_valid", 32'(valid), 32'd1);
        check("pend55_data", 32'(data), 32'h55);
        ov0 = ov_cnt; acc0 = acc_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_cycles(2 + HALF + 9 * B);
                ready = 1'b1;
                wait_cycles(1);
                ready = 1'b0;
            end
        join
        check("collide_valid", 32'(valid), 32'd1);
        check("collide_data", 32'(data), 32'h77);
        check("collide_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("collide_accepts", 32'(acc_cnt - acc0), 32'd1);
        check("collide_acc_data", 32'(last_acc), 32'h55);

        // Reset during data bit 3, with a word still pending.
        busy_rel = 0;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_cycles(4 * B + B / 2);
                check("midrst_busy_before", 32'(busy), 32'd1);
                reset = 1'b1;
                #1;
                check("midrst_valid", 32'(valid), 32'd0);
                check("midrst_data", 32'(data), 32'd0);
                check("midrst_frame_err", 32'(frame_err), 32'd0);
                check("midrst_overrun", 32'(overrun), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                wait_cycles(B);
                reset = 1'b0;
                busy_rel = busy_cnt;
            end
        join
        check("midrst_no_restart", 32'(busy_cnt - busy_rel), 32'd0);
        line = 1'b1;
        wait_cycles(B);

        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h0F, 1'b1);
        check("after_rst_valid", 32'(valid), 32'd1);
        check("after_rst_data", 32'(data), 32'h0F);
        check("after_rst_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("after_rst_overrun", 32'(ov_cnt - ov0), 32'd0);
        acc0 = acc_cnt;
        ready = 1'b1;
        wait_cycles(3);
        ready = 1'b0;
        check("after_rst_accepts", 32'(acc_cnt - acc0), 32'd1);
        check("after_rst_acc_data", 32'(last_acc), 32'h0F);
        check("after_rst_valid_clr", 32'(valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
